// File: rtl/if_fetch_if.sv
// Byte-wide read port shared between the fetch stage and the memory arbiter.
// One request in flight at a time: req/gnt handshake, then a single rvalid byte.
interface if_fetch_if;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_gnt_i;
  logic        mem_rvalid_i;
  logic [7:0]  mem_rdata_i;

  modport master (
    output mem_req_o, mem_addr_o,
    input  mem_gnt_i, mem_rvalid_i, mem_rdata_i
  );

  modport slave (
    input  mem_req_o, mem_addr_o,
    output mem_gnt_i, mem_rvalid_i, mem_rdata_i
  );
endinterface

// File: rtl/if_fetch.sv
// RV32I instruction-fetch stage: four byte reads per instruction, little-endian
// assembly, stall hold at the IF/ID boundary and branch redirect with drain.
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_i,
  input  logic              branch_i,
  input  logic [31:0]       branch_target_i,
  if_fetch_if.master        mem,
  output logic [31:0]       pc_o,
  output logic [31:0]       inst_o,
  output logic              inst_valid_o
);

  typedef enum logic [1:0] {ISSUE, WAIT, HOLD, DRAIN} state_e;

  state_e      state_q,    state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [23:0] byte_buf_q, byte_buf_d;
  logic [31:0] pc_q,       pc_d;
  logic [31:0] inst_q,     inst_d;
  logic        valid_q,    valid_d;
  logic        outstanding;

  // Request is gated by reset so nothing is issued while held in reset.
  assign mem.mem_req_o  = rst & (state_q == ISSUE);
  assign mem.mem_addr_o = {fetch_pc_q[31:2], fetch_pc_q[1:0] + byte_cnt_q};

  assign pc_o         = pc_q;
  assign inst_o       = inst_q;
  assign inst_valid_o = valid_q;

  // A byte is still owed to us after this edge if it was granted but not yet returned.
  assign outstanding = ((state_q == WAIT)  && !mem.mem_rvalid_i) ||
                       ((state_q == ISSUE) &&  mem.mem_gnt_i)    ||
                       ((state_q == DRAIN) && !mem.mem_rvalid_i);

  always_comb begin
    // NOTE: every signal gets its hold value first so no path leaves it unassigned (no latches).
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    byte_cnt_d = byte_cnt_q;
    byte_buf_d = byte_buf_q;
    pc_d       = pc_q;
    inst_d     = inst_q;
    valid_d    = valid_q;

    unique case (state_q)
      ISSUE: begin
        if (mem.mem_gnt_i) state_d = WAIT;
      end
      WAIT: begin
        if (mem.mem_rvalid_i) begin
          unique case (byte_cnt_q)
            2'd0: byte_buf_d[7:0]   = mem.mem_rdata_i;
            2'd1: byte_buf_d[15:8]  = mem.mem_rdata_i;
            2'd2: byte_buf_d[23:16] = mem.mem_rdata_i;
            2'd3: begin
              inst_d  = {mem.mem_rdata_i, byte_buf_q};
              pc_d    = fetch_pc_q;
              valid_d = 1'b1;
            end
          endcase
          if (byte_cnt_q == 2'd3) begin
            state_d = HOLD;
          end else begin
            byte_cnt_d = byte_cnt_q + 2'd1;
            state_d    = ISSUE;
          end
        end
      end
      HOLD: begin
        if (!stall_i) begin
          fetch_pc_d = fetch_pc_q + 32'd4;
          byte_cnt_d = 2'd0;
          valid_d    = 1'b0;
          state_d    = ISSUE;
        end
      end
      DRAIN: begin
        if (mem.mem_rvalid_i) state_d = ISSUE;
      end
    endcase

    // Redirect overrides everything; the completed-instruction registers keep their old contents.
    if (branch_i) begin
      fetch_pc_d = {branch_target_i[31:2], 2'b00};
      byte_cnt_d = 2'd0;
      pc_d       = pc_q;
      inst_d     = inst_q;
      valid_d    = 1'b0;
      state_d    = outstanding ? DRAIN : ISSUE;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ISSUE;
      fetch_pc_q <= RESET_PC;
      byte_cnt_q <= 2'd0;
      byte_buf_q <= 24'd0;
      pc_q       <= RESET_PC;
      inst_q     <= 32'd0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      byte_cnt_q <= byte_cnt_d;
      byte_buf_q <= byte_buf_d;
      pc_q       <= pc_d;
      inst_q     <= inst_d;
      valid_q    <= valid_d;
    end
  end

endmodule
